execute_out_buffer: RTL and testbench
=====================================

# execute_out_buffer

Parametrised elastic buffer for the LC3 execute-stage output bundle, sitting between the execute stage and memory-access/writeback. It holds up to DEPTH execute results in FIFO order and decouples the two stages with a valid/ready handshake, so execute can run ahead while downstream stalls. It also supports a synchronous pipeline flush for branch redirect and reports its occupancy.

## Interface
Parameters:
- DATA_W, 16, width of aluout, pcout, IR_Exec, M_data fields
- REG_W, 3, width of dr, sr1, sr2 fields
- DEPTH, 2, number of entries; power of two, ≥ 2
- PAYLOAD_W, 4*DATA_W+3*REG_W+6, derived; packed payload width (79 at defaults)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  execute result present
- in_ready  output  1  buffer can accept this cycle
- in_data  input  PAYLOAD_W  packed {W_Control_out[1:0], Mem_Control_out, aluout, pcout, dr, sr1, sr2, IR_Exec, NZP[2:0], M_data}, MSB first
- flush  input  1  discard all stored entries
- out_valid  output  1  head entry available
- out_ready  input  1  downstream consumes head
- out_data  output  PAYLOAD_W  head entry, same packing as in_data
- en_ex  output  1  equals out_valid; enable to downstream stage
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry register array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy counter count ranges 0..DEPTH.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so a full buffer refuses a push even while popping.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else all zeros.
- On push: mem[wr_ptr] <= in_data, wr_ptr++. On pop: rd_ptr++.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together (possible only when 0 < count < DEPTH): count unchanged
- flush (synchronous, highest priority): wr_ptr, rd_ptr and count go to 0. push and pop are suppressed that cycle, so the entry offered on in_data is dropped. Array contents are not cleared.
- Reset (asynchronous, active-low, any time including mid-transfer):
  - wr_ptr, rd_ptr, count = 0
  - out_valid = 0, en_ex = 0, out_data = 0, in_ready = 1
  - array contents are don't-care
- Ordering: strict FIFO. No entry is duplicated or reordered.

## Timing
- Latency: an entry pushed at edge N is visible on out_data with out_valid = 1 after edge N (first cycle N+1) if the buffer was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full (count = DEPTH): in_ready = 0 in the same cycle count reaches DEPTH. It returns to 1 the cycle after the first pop.
- Empty: out_valid = 0. in_valid in this cycle does not produce out_valid until the next cycle (no bypass).
- Handshake: the producer must hold in_data stable while in_valid = 1 and in_ready = 0. out_data stays stable while out_valid = 1 and out_ready = 0.
- Pointer wrap: wr_ptr = DEPTH-1 plus push gives wr_ptr = 0. rd_ptr wraps the same way.
- flush with in_valid = 1: the cycle after flush, count = 0, out_valid = 0, in_ready = 1.
- reset release: the first push is accepted on the first rising edge at which reset is high.

## Test plan
- Reset: drive reset = 0 mid-stream with count = 2 → out_valid = 0, en_ex = 0, count = 0, in_ready = 1, out_data = 0 immediately, without waiting for a clock edge.
- Fill/drain: hold out_ready = 0 and push aluout = 16'h0001, 16'h0002 → count = 2, in_ready = 0. A third push is held off. Then set out_ready = 1 → outputs 0001 then 0002 in order, then out_valid = 0.
- Streaming: DEPTH = 4, in_valid = out_ready = 1 for 20 cycles with incrementing IR_Exec → one output per cycle after 1-cycle latency, count steady at 1, no gaps.
- Wrap-around: DEPTH = 4, with random stalls push 10 entries whose pcout = 16'h3000+i → all 10 drain in order while both pointers wrap twice.
- Flush: count = 3 and in_valid = 1 with flush = 1 → next cycle count = 0, out_valid = 0. The offered entry never appears at the output.
- Full simultaneous: with count = DEPTH assert in_valid and out_ready → pop occurs, push is refused, count = DEPTH-1, and the push is accepted on the following cycle.

Source files
------------

// File: rtl/execute_out_buffer_if.sv
// Handshake bundle between the execute stage, the output buffer and the
// memory-access/writeback consumer.
interface execute_out_buffer_if #(
  parameter int DATA_W    = 16,
  parameter int REG_W     = 3,
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 4*DATA_W + 3*REG_W + 6,
  parameter int CNT_W     = $clog2(DEPTH+1)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_data;
  logic                 en_ex;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, en_ex, count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, en_ex, count
  );
endinterface

// File: rtl/execute_out_buffer.sv
// Elastic FIFO between LC3 execute and memory-access/writeback: DEPTH entries,
// valid/ready on both sides, synchronous flush for branch redirect.
module execute_out_buffer #(
  parameter int DATA_W    = 16,
  parameter int REG_W     = 3,
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 4*DATA_W + 3*REG_W + 6
) (
  input  logic               clock,
  input  logic               reset,
  execute_out_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PAYLOAD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // in_ready looks only at occupancy, so a full buffer never accepts on a pop cycle
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full & ~bus.flush;
  assign w_pop   = ~w_empty & bus.out_ready & ~bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; stale entries are masked by the occupancy count
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.en_ex     = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.count     = r_count;
endmodule

// File: tb/tb_execute_out_buffer.sv
// Bench for execute_out_buffer: table vectors, hand sequences and random traffic
// checked against a queue model of the FIFO.
module tb_execute_out_buffer;
  localparam int DEPTH = 4;
  localparam int PW    = 79;

  typedef struct packed {
    logic [1:0]  wctl;
    logic        mctl;
    logic [15:0] alu;
    logic [15:0] pc;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic [15:0] m;
  } pl_t;

  typedef struct {
    logic        v;
    logic        f;
    logic        r;
    logic [15:0] alu;
    int          ecnt;
    logic        eov;
    logic        eir;
    logic [15:0] ealu;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [PW-1:0] q[$];

  always #5 clock = ~clock;

  execute_out_buffer_if #(.DEPTH(DEPTH)) bus();

  execute_out_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [PW-1:0] mk(input logic [15:0] a, input logic [15:0] pc, input logic [15:0] ir);
    pl_t p;
    p.wctl = a[1:0]; p.mctl = a[2]; p.alu = a; p.pc = pc;
    p.dr = a[5:3]; p.sr1 = a[8:6]; p.sr2 = a[11:9];
    p.ir = ir; p.nzp = a[14:12]; p.m = a ^ 16'hA5A5;
    return p;
  endfunction

  function automatic logic [PW-1:0] mka(input logic [15:0] a);
    return mk(a, ~a, a + 16'd1);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [PW-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".count"},     128'(bus.count),     128'(q.size()));
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(q.size() != 0));
    chk({tag, ".en_ex"},     128'(bus.en_ex),     128'(q.size() != 0));
    chk({tag, ".in_ready"},  128'(bus.in_ready),  128'(q.size() != DEPTH));
    chk({tag, ".out_data"},  128'(bus.out_data),  128'(head));
  endtask

  // One clock: drive at negedge, check against the model, advance the model on posedge
  task automatic drive(input logic v, input logic [PW-1:0] d, input logic f, input logic r,
                       output logic acc, output logic popd, output logic [PW-1:0] pdata);
    @(negedge clock);
    bus.in_valid = v; bus.in_data = d; bus.flush = f; bus.out_ready = r;
    #1;
    chk_model("model");
    acc   = v && (q.size() < DEPTH) && !f;
    popd  = r && (q.size() > 0) && !f;
    pdata = (q.size() > 0) ? q[0] : '0;
    @(posedge clock);
    if (f) q.delete();
    else begin
      if (popd) void'(q.pop_front());
      if (acc)  q.push_back(d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[20];
    logic acc, popd;
    logic [PW-1:0] pd;
    logic [15:0] seen[$];
    pl_t hp;
    int sent, cyc;

    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.out_ready = 0;
    #12;
    chk("rst.count", 128'(bus.count), 0);
    chk("rst.out_valid", 128'(bus.out_valid), 0);
    chk("rst.en_ex", 128'(bus.en_ex), 0);
    chk("rst.in_ready", 128'(bus.in_ready), 1);
    chk("rst.out_data", 128'(bus.out_data), 0);
    @(negedge clock); reset = 1'b1;

    // {v, f, r, alu} -> state after the edge {count, out_valid, in_ready, head alu}
    tbl[0]  = '{1,0,0,16'h0001, 1,1,1,16'h0001};
    tbl[1]  = '{1,0,0,16'h0002, 2,1,1,16'h0001};
    tbl[2]  = '{1,0,0,16'h0003, 3,1,1,16'h0001};
    tbl[3]  = '{1,0,0,16'h0004, 4,1,0,16'h0001};
    tbl[4]  = '{1,0,0,16'h0005, 4,1,0,16'h0001};
    tbl[5]  = '{0,0,1,16'h0000, 3,1,1,16'h0002};
    tbl[6]  = '{0,0,1,16'h0000, 2,1,1,16'h0003};
    tbl[7]  = '{0,0,1,16'h0000, 1,1,1,16'h0004};
    tbl[8]  = '{0,0,1,16'h0000, 0,0,1,16'h0000};
    tbl[9]  = '{1,0,0,16'h0011, 1,1,1,16'h0011};
    tbl[10] = '{1,0,0,16'h0012, 2,1,1,16'h0011};
    tbl[11] = '{1,0,0,16'h0013, 3,1,1,16'h0011};
    tbl[12] = '{1,0,0,16'h0014, 4,1,0,16'h0011};
    tbl[13] = '{1,0,1,16'h0015, 3,1,1,16'h0012};
    tbl[14] = '{1,0,0,16'h0015, 4,1,0,16'h0012};
    tbl[15] = '{0,0,1,16'h0000, 3,1,1,16'h0013};
    tbl[16] = '{1,1,1,16'h0099, 0,0,1,16'h0000};
    tbl[17] = '{0,0,1,16'h0000, 0,0,1,16'h0000};
    tbl[18] = '{1,0,0,16'h0021, 1,1,1,16'h0021};
    tbl[19] = '{0,0,1,16'h0000, 0,0,1,16'h0000};
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, mka(tbl[i].alu), tbl[i].f, tbl[i].r, acc, popd, pd);
      #1;
      chk($sformatf("vec%0d.count", i),     128'(bus.count),     128'(tbl[i].ecnt));
      chk($sformatf("vec%0d.out_valid", i), 128'(bus.out_valid), 128'(tbl[i].eov));
      chk($sformatf("vec%0d.in_ready", i),  128'(bus.in_ready),  128'(tbl[i].eir));
      chk($sformatf("vec%0d.out_data", i),  128'(bus.out_data),
          tbl[i].eov ? 128'(mka(tbl[i].ealu)) : 128'(0));
    end

    // Streaming: one in, one out per cycle, occupancy pinned at 1
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, mk(16'h0100, 16'h0200, 16'(i)), 1'b0, 1'b1, acc, popd, pd);
      #1;
      hp = pl_t'(bus.out_data);
      chk($sformatf("stream%0d.count", i), 128'(bus.count), 1);
      chk($sformatf("stream%0d.ir", i), 128'(hp.ir), 128'(i));
    end
    drive(1'b0, '0, 1'b0, 1'b1, acc, popd, pd);

    // Wrap-around: 10 entries with random stalls must drain in order
    sent = 0; cyc = 0;
    while ((sent < 10 || q.size() != 0) && cyc < 300) begin
      drive((sent < 10) && ($urandom_range(0, 2) != 0), mk(16'h0055, 16'h3000 + 16'(sent), 16'h0),
            1'b0, $urandom_range(0, 2) != 0, acc, popd, pd);
      if (acc) sent++;
      if (popd) begin hp = pl_t'(pd); seen.push_back(hp.pc); end
      cyc++;
    end
    chk("wrap.timeout", 128'(cyc < 300), 1);
    chk("wrap.n", 128'(seen.size()), 10);
    for (int i = 0; i < 10 && i < seen.size(); i++)
      chk($sformatf("wrap.pc%0d", i), 128'(seen[i]), 128'(16'h3000 + 16'(i)));

    // Random traffic including occasional flush
    for (int i = 0; i < 400; i++) begin
      logic [95:0] rr;
      rr = {$urandom, $urandom, $urandom};
      drive($urandom_range(0, 1) == 1, rr[PW-1:0], $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, acc, popd, pd);
    end
    drive(1'b0, '0, 1'b1, 1'b0, acc, popd, pd);

    // Async reset with two entries stored, then first push right at release
    drive(1'b1, mka(16'h0A01), 1'b0, 1'b0, acc, popd, pd);
    drive(1'b1, mka(16'h0A02), 1'b0, 1'b0, acc, popd, pd);
    @(negedge clock);
    bus.in_valid = 0;
    #1;
    chk("mid.count_before", 128'(bus.count), 2);
    #1;
    reset = 1'b0;
    #1;
    chk("arst.out_valid", 128'(bus.out_valid), 0);
    chk("arst.en_ex", 128'(bus.en_ex), 0);
    chk("arst.count", 128'(bus.count), 0);
    chk("arst.in_ready", 128'(bus.in_ready), 1);
    chk("arst.out_data", 128'(bus.out_data), 0);
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1; bus.in_data = mka(16'h0B0B); bus.out_ready = 0;
    @(posedge clock);
    #1;
    chk("rel.count", 128'(bus.count), 1);
    chk("rel.out_data", 128'(bus.out_data), 128'(mka(16'h0B0B)));
    bus.in_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
